// File: rtl/mdu_sequencer_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: funct3 selects,
// FSM state codes and the fixed iteration/latency figures.
package mdu_sequencer_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int MDU_ITER    = 32;
  localparam int MDU_LATENCY = 35;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 step: shift-add for multiply over {acc, multiplier}, or
// restoring shift-subtract for divide over {remainder, quotient}.
module mdu_iter_step (
  input  logic        is_div_i,
  input  logic [63:0] work_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] work_o
);

  logic [32:0] sum;
  logic        fits;
  logic [31:0] rem_sub;

  always_comb begin
    sum     = {1'b0, work_i[63:32]} + {1'b0, (work_i[0] ? opnd_i : 32'd0)};
    // The shifted remainder is 33 bits wide; compare before subtracting.
    fits    = (work_i[63:31] >= {1'b0, opnd_i});
    rem_sub = work_i[62:31] - opnd_i;
    if (is_div_i) begin
      work_o = fits ? {rem_sub, work_i[30:0], 1'b1} : {work_i[62:0], 1'b0};
    end else begin
      work_o = {sum, work_i[31:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: fixed 35-cycle latency from accept to
// oDone. Handshake: iStart is taken only in IDLE without iAbort; oDone pulses once.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic        iAbort,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oResult,
  output logic [2:0]  oState
);

  mdu_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [31:0] a_q, b_q, opnd_q, result_q;
  logic [63:0] work_q, work_d;
  logic        neg_q, busy_q, done_q;

  logic        is_div, sgn_a, sgn_b, neg_a, neg_b, neg_d;
  logic [31:0] abs_a, abs_b, q_fix, r_fix, result_d;
  logic [63:0] prod_fix;

  always_comb begin
    is_div = f3_q[2];
    sgn_a  = is_div ? ~f3_q[0] : (f3_q == F3_MULH || f3_q == F3_MULHSU);
    sgn_b  = is_div ? ~f3_q[0] : (f3_q == F3_MULH);
    neg_a  = sgn_a & a_q[31];
    neg_b  = sgn_b & b_q[31];
    abs_a  = neg_a ? -a_q : a_q;
    abs_b  = neg_b ? -b_q : b_q;
    // A zero divisor yields all-ones quotient regardless of operand signs.
    if (!is_div)       neg_d = neg_a ^ neg_b;
    else if (f3_q[1])  neg_d = neg_a;
    else               neg_d = (neg_a ^ neg_b) & (b_q != 32'd0);

    prod_fix = neg_q ? -work_q : work_q;
    q_fix    = neg_q ? -work_q[31:0] : work_q[31:0];
    r_fix    = neg_q ? -work_q[63:32] : work_q[63:32];
    if (!is_div) result_d = (f3_q == F3_MUL) ? prod_fix[31:0] : prod_fix[63:32];
    else         result_d = f3_q[1] ? r_fix : q_fix;
  end

  mdu_iter_step u_step (
    .is_div_i (is_div),
    .work_i   (work_q),
    .opnd_i   (opnd_q),
    .work_o   (work_d)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      f3_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      opnd_q   <= 32'd0;
      work_q   <= 64'd0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else if (iAbort) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (iStart) begin
            f3_q    <= iFunct3;
            a_q     <= iA;
            b_q     <= iB;
            busy_q  <= 1'b1;
            state_q <= ST_PREP;
          end
        end
        ST_PREP: begin
          work_q  <= {32'd0, abs_a};
          opnd_q  <= abs_b;
          neg_q   <= neg_d;
          cnt_q   <= 6'd0;
          state_q <= ST_CALC;
        end
        ST_CALC: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 6'd1;
          if (cnt_q == 6'(MDU_ITER - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oResult = result_q;
  assign oState  = state_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed arithmetic, random ops against a reference
// model, and start/abort/reset control scenarios with cycle-exact timing checks.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iStart = 1'b0;
  logic        iAbort = 1'b0;
  logic [2:0]  iFunct3 = 3'd0;
  logic [31:0] iA = 32'd0;
  logic [31:0] iB = 32'd0;
  logic        oBusy, oDone;
  logic [31:0] oResult;
  logic [2:0]  oState;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic        busy_tr [0:99];
  logic        done_tr [0:99];
  logic [31:0] res_tr  [0:99];
  int          done_cnt, first_done;

  mdu_sequencer dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iAbort(iAbort),
    .iFunct3(iFunct3), .iA(iA), .iB(iB),
    .oBusy(oBusy), .oDone(oDone), .oResult(oResult), .oState(oState)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (f3)
      F3_MUL:    begin p = ua * ub; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = ia / ib; return r;
      end
      F3_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = ia % ib; return r;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Driver: present one request for the accept edge and queue its expected result.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge iCLK);
    iStart = 1'b1; iFunct3 = f3; iA = a; iB = b;
    exp_q.push_back(ref_mdu(f3, a, b));
    @(posedge iCLK);
    #1 iStart = 1'b0;
  endtask

  // Driver/monitor: cycle c is the c-th cycle after the accept edge.
  task automatic run_cycles(input int n, input int st_from, input int st_to,
                            input logic [2:0] st_f3, input logic [31:0] st_a,
                            input logic [31:0] st_b, input int abort_at, input int rst_at);
    done_cnt = 0;
    first_done = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge iCLK);
      busy_tr[c] = oBusy;
      done_tr[c] = oDone;
      res_tr[c]  = oResult;
      if (oDone === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
        got_q.push_back(oResult);
      end
      iStart = (c >= st_from) && (c <= st_to);
      if (c == st_from) begin iFunct3 = st_f3; iA = st_a; iB = st_b; end
      iAbort = (c == abort_at);
      iRST   = (c == rst_at);
    end
    iStart = 1'b0; iAbort = 1'b0; iRST = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    n_cmp += 4;
    if (oBusy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b need 0", oBusy); end
    if (oDone !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b need 0", oDone); end
    if (oResult !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h need 0", oResult); end
    if (oState !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d need 0", oState); end
    iRST = 1'b0;
  endtask

  task automatic test_arith();
    logic [2:0]  f3s [0:11] = '{F3_MUL, F3_MULHU, F3_MULH, F3_MULHSU, F3_DIV, F3_REM,
                                F3_DIVU, F3_REMU, F3_DIVU, F3_REM, F3_DIV, F3_REM};
    logic [31:0] as  [0:11] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [0:11] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] req [0:11] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF,
                                32'd5, 32'h8000_0000, 32'h0};
    logic [31:0] exp_v, got_v;
    int busy_bad;
    for (int i = 0; i < 12; i++) begin
      issue(f3s[i], as[i], bs[i]);
      run_cycles(37, 0, 0, 3'd0, 32'd0, 32'd0, 0, 0);
      busy_bad = 0;
      for (int c = 1; c <= 36; c++)
        if (busy_tr[c] !== ((c < MDU_LATENCY) ? 1'b1 : 1'b0)) busy_bad++;
      exp_v = exp_q.pop_front();
      n_cmp += 6;
      if (exp_v !== req[i]) begin
        n_bad++; $display("FAIL model_%0d: model %h table %h", i, exp_v, req[i]);
      end
      if (first_done != MDU_LATENCY) begin
        n_bad++; $display("FAIL latency_%0d: got %0d need %0d", i, first_done, MDU_LATENCY);
      end
      if (done_cnt != 1) begin
        n_bad++; $display("FAIL done_count_%0d: got %0d need 1", i, done_cnt);
      end
      if (busy_bad != 0) begin
        n_bad++; $display("FAIL busy_window_%0d: got %0d bad cycles need 0", i, busy_bad);
      end
      got_v = (got_q.size() > 0) ? got_q.pop_front() : 32'hDEAD_BEEF;
      if (got_v !== exp_v) begin
        n_bad++; $display("FAIL result_%0d: got %h need %h", i, got_v, exp_v);
      end
      if (res_tr[37] !== exp_v) begin
        n_bad++; $display("FAIL hold_%0d: got %h need %h", i, res_tr[37], exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp_v, got_v;
    logic [2:0]  f3;
    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) b = -b;
      issue(f3, a, b);
      run_cycles(36, 0, 0, 3'd0, 32'd0, 32'd0, 0, 0);
      exp_v = exp_q.pop_front();
      got_v = (got_q.size() > 0) ? got_q.pop_front() : ~exp_v;
      n_cmp += 2;
      if (first_done != MDU_LATENCY) begin
        n_bad++; $display("FAIL rand_latency_%0d: got %0d need %0d", i, first_done, MDU_LATENCY);
      end
      if (got_v !== exp_v) begin
        n_bad++; $display("FAIL rand_result_%0d f3=%0d a=%h b=%h: got %h need %h",
                          i, f3, a, b, got_v, exp_v);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] exp_v, got_v;
    issue(F3_DIVU, 32'd1000, 32'd9);
    run_cycles(45, 10, 10, F3_MUL, 32'd3, 32'd3, 0, 0);
    exp_v = exp_q.pop_front();
    got_v = (got_q.size() > 0) ? got_q.pop_front() : ~exp_v;
    got_q.delete();
    n_cmp += 3;
    if (done_cnt != 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d need 1", done_cnt); end
    if (first_done != MDU_LATENCY) begin
      n_bad++; $display("FAIL ignore_latency: got %0d need %0d", first_done, MDU_LATENCY);
    end
    if (got_v !== exp_v) begin n_bad++; $display("FAIL ignore_result: got %h need %h", got_v, exp_v); end
  endtask

  task automatic test_abort();
    logic [31:0] held;
    held = ref_mdu(F3_DIVU, 32'd1000, 32'd9);
    issue(F3_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
    run_cycles(40, 0, 0, 3'd0, 32'd0, 32'd0, 20, 0);
    exp_q.delete();
    got_q.delete();
    n_cmp += 4;
    if (busy_tr[20] !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b need 1", busy_tr[20]); end
    if (busy_tr[21] !== 1'b0) begin n_bad++; $display("FAIL abort_busy_after: got %b need 0", busy_tr[21]); end
    if (done_cnt != 0) begin n_bad++; $display("FAIL abort_done_count: got %0d need 0", done_cnt); end
    if (res_tr[40] !== held) begin n_bad++; $display("FAIL abort_result_held: got %h need %h", res_tr[40], held); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_v, got_v;
    issue(F3_REM, 32'hFFFF_FF00, 32'd7);
    run_cycles(40, 0, 0, 3'd0, 32'd0, 32'd0, 0, 12);
    exp_q.delete();
    got_q.delete();
    n_cmp += 5;
    if (busy_tr[12] !== 1'b1) begin n_bad++; $display("FAIL rst_busy_before: got %b need 1", busy_tr[12]); end
    if (busy_tr[13] !== 1'b0) begin n_bad++; $display("FAIL rst_busy_after: got %b need 0", busy_tr[13]); end
    if (done_tr[13] !== 1'b0) begin n_bad++; $display("FAIL rst_done_after: got %b need 0", done_tr[13]); end
    if (res_tr[13] !== 32'd0) begin n_bad++; $display("FAIL rst_result_after: got %h need 0", res_tr[13]); end
    if (done_cnt != 0) begin n_bad++; $display("FAIL rst_done_count: got %0d need 0", done_cnt); end
    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD);
    run_cycles(36, 0, 0, 3'd0, 32'd0, 32'd0, 0, 0);
    exp_v = exp_q.pop_front();
    got_v = (got_q.size() > 0) ? got_q.pop_front() : ~exp_v;
    n_cmp += 2;
    if (first_done != MDU_LATENCY) begin
      n_bad++; $display("FAIL rst_restart_latency: got %0d need %0d", first_done, MDU_LATENCY);
    end
    if (got_v !== exp_v) begin n_bad++; $display("FAIL rst_restart_result: got %h need %h", got_v, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2, g1, g2;
    issue(F3_MULHU, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    exp_q.push_back(ref_mdu(F3_DIV, 32'hFFFF_F000, 32'd3));
    run_cycles(75, 35, 36, F3_DIV, 32'hFFFF_F000, 32'd3, 0, 0);
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    g1 = (got_q.size() > 0) ? got_q.pop_front() : ~e1;
    g2 = (got_q.size() > 0) ? got_q.pop_front() : ~e2;
    got_q.delete();
    n_cmp += 6;
    if (done_cnt != 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d need 2", done_cnt); end
    if (busy_tr[36] !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap: got %b need 0", busy_tr[36]); end
    if (busy_tr[37] !== 1'b1) begin n_bad++; $display("FAIL b2b_second_busy: got %b need 1", busy_tr[37]); end
    if (done_tr[71] !== 1'b1) begin n_bad++; $display("FAIL b2b_second_latency: got %b need 1", done_tr[71]); end
    if (g1 !== e1) begin n_bad++; $display("FAIL b2b_result1: got %h need %h", g1, e1); end
    if (g2 !== e2) begin n_bad++; $display("FAIL b2b_result2: got %h need %h", g2, e2); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_random();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
